// File: rtl/pswitch_oq_merge.sv
// Packet-level 2:1 round-robin merger (parser bypass + aggregator result) with a one-deep output slice.
// Optional per-input packet counters are built when PSW_MERGE_STATS_EN is defined.
module pswitch_oq_merge #(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_byp_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_byp_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_byp_tuser,
    input  logic                                 s_axis_byp_tvalid,
    input  logic                                 s_axis_byp_tlast,
    output logic                                 s_axis_byp_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_agg_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_agg_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_agg_tuser,
    input  logic                                 s_axis_agg_tvalid,
    input  logic                                 s_axis_agg_tlast,
    output logic                                 s_axis_agg_tready,

`ifdef PSW_MERGE_STATS_EN
    output logic [31:0]                          byp_pkt_count,
    output logic [31:0]                          agg_pkt_count,
`endif

    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready
);

    localparam int unsigned DW  = C_M_AXIS_DATA_WIDTH;
    localparam int unsigned KW  = C_M_AXIS_DATA_WIDTH / 8;
    localparam int unsigned UW  = C_M_AXIS_TUSER_WIDTH;
    localparam int unsigned SDW = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned SKW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned SUW = C_S_AXIS_TUSER_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BYP_PKT = 2'd1,
        AGG_PKT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rr_ptr;
    logic            rr_ptr_nxt;
    logic            slot_free_c;
    logic            load_byp_c;
    logic            load_agg_c;
    logic            load_c;
    logic [SDW-1:0]  ld_data_c;
    logic [SKW-1:0]  ld_keep_c;
    logic [SUW-1:0]  ld_user_c;
    logic            ld_last_c;

    // The output slice can take a beat when empty or draining this cycle.
    assign slot_free_c = ~m_axis_tvalid | m_axis_tready;
    assign load_c      = load_byp_c | load_agg_c;

    // State and round-robin pointer registers.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Grant selection in IDLE; granted input streams until its tlast beat is taken.
    always_comb begin
        state_nxt         = state;
        rr_ptr_nxt        = rr_ptr;
        s_axis_byp_tready = 1'b0;
        s_axis_agg_tready = 1'b0;
        load_byp_c        = 1'b0;
        load_agg_c        = 1'b0;
        case (state)
            IDLE: begin
                if (s_axis_byp_tvalid && s_axis_agg_tvalid) begin
                    state_nxt = rr_ptr ? AGG_PKT : BYP_PKT;
                end else if (s_axis_byp_tvalid) begin
                    state_nxt = BYP_PKT;
                end else if (s_axis_agg_tvalid) begin
                    state_nxt = AGG_PKT;
                end
            end
            BYP_PKT: begin
                s_axis_byp_tready = slot_free_c;
                if (s_axis_byp_tvalid && slot_free_c) begin
                    load_byp_c = 1'b1;
                    if (s_axis_byp_tlast) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = 1'b1;
                    end
                end
            end
            AGG_PKT: begin
                s_axis_agg_tready = slot_free_c;
                if (s_axis_agg_tvalid && slot_free_c) begin
                    load_agg_c = 1'b1;
                    if (s_axis_agg_tlast) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Beat selected for loading into the output slice.
    always_comb begin
        ld_data_c = s_axis_byp_tdata;
        ld_keep_c = s_axis_byp_tkeep;
        ld_user_c = s_axis_byp_tuser;
        ld_last_c = s_axis_byp_tlast;
        if (load_agg_c) begin
            ld_data_c = s_axis_agg_tdata;
            ld_keep_c = s_axis_agg_tkeep;
            ld_user_c = s_axis_agg_tuser;
            ld_last_c = s_axis_agg_tlast;
        end
    end

    // One-deep output register; fields only change on a load so they hold while stalled.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load_c) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= DW'(ld_data_c);
            m_axis_tkeep  <= KW'(ld_keep_c);
            m_axis_tuser  <= UW'(ld_user_c);
            m_axis_tlast  <= ld_last_c;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef PSW_MERGE_STATS_EN
    // Completed-packet counters; only one input holds the grant so they never step together.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            byp_pkt_count <= 32'd0;
            agg_pkt_count <= 32'd0;
        end else begin
            if (load_byp_c && s_axis_byp_tlast) begin
                byp_pkt_count <= byp_pkt_count + 32'd1;
            end
            if (load_agg_c && s_axis_agg_tlast) begin
                agg_pkt_count <= agg_pkt_count + 32'd1;
            end
        end
    end
`endif

endmodule
